// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the 22-bit physical memory bus between the Z80 and the LCD fetch
// engine. The CPU normally owns the bus; the LCD is granted idle slots, or
// steals a CPU read once its request has waited STARVE_LIMIT cycles. A CPU
// write is never interrupted. During an LCD access, and the turnaround cycle
// after it, any CPU memory cycle is held off with wait_n.
//
// Ports:
//   mck       in   master clock
//   rin       in   synchronous active-high reset
//   cpu_ma    in   22-bit physical address from segment decode
//   cpu_mrq_n in   Z80 MREQ (active low)
//   cpu_rd_n  in   Z80 RD (active low)
//   lcd_en    in   LCD fetch enable
//   lcd_req   in   LCD fetch request (level)
//   lcd_addr  in   LCD fetch address, captured at grant
//   mem_di    in   memory read data
//   ma        out  physical address to the memory slots
//   roe_n     out  memory output enable (active low)
//   wrb_n     out  memory write enable (active low)
//   wait_n    out  Z80 WAIT (active low)
//   lcd_gnt   out  high while the LCD owns the bus
//   lcd_ack   out  one-cycle pulse, lcd_data valid
//   lcd_data  out  fetched byte, registered
//   busy      out  arbiter not idle

module mem_arbiter #(
    parameter int ACC_CYC      = 2,
    parameter int STARVE_LIMIT = 24
) (
    input  logic        mck,
    input  logic        rin,
    input  logic [21:0] cpu_ma,
    input  logic        cpu_mrq_n,
    input  logic        cpu_rd_n,
    input  logic        lcd_en,
    input  logic        lcd_req,
    input  logic [21:0] lcd_addr,
    input  logic [7:0]  mem_di,
    output logic [21:0] ma,
    output logic        roe_n,
    output logic        wrb_n,
    output logic        wait_n,
    output logic        lcd_gnt,
    output logic        lcd_ack,
    output logic [7:0]  lcd_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LACC = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [3:0] ACC_LOAD   = 4'(ACC_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic [3:0]  acc_q, acc_d;
    logic [21:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        ack_q, ack_d;
    logic        grant;
    logic        pending;

    // A request only counts while fetching is enabled. Once starved, the LCD
    // may take the bus from a CPU read, but a write (RD high) must finish.
    assign pending = lcd_en & lcd_req;
    assign grant   = (state_q == IDLE) & pending &
                     (cpu_mrq_n | ((starve_q == STARVE_MAX) & ~cpu_rd_n));

    // State and datapath registers. Reset aborts any access in flight, so an
    // interrupted fetch never produces an ack.
    always_ff @(posedge mck) begin
        if (rin) begin
            state_q  <= IDLE;
            starve_q <= 8'd0;
            acc_q    <= 4'd0;
            addr_q   <= 22'd0;
            data_q   <= 8'h00;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state logic. The ack is registered as the access ends, so it
    // coincides with the turnaround cycle.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        acc_d    = acc_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = LACC;
                    addr_d   = lcd_addr;
                    acc_d    = ACC_LOAD;
                    starve_d = 8'd0;
                end else if (pending && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + 8'd1;
                end
            end
            LACC: begin
                if (acc_q == 4'd0) begin
                    data_d  = mem_di;
                    ack_d   = 1'b1;
                    state_d = TURN;
                end else begin
                    acc_d = acc_q - 4'd1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!pending) begin
            starve_d = 8'd0;
        end
    end

    // Bus mux and status outputs, decoded from the registered state.
    always_comb begin
        ma      = cpu_ma;
        roe_n   = ~(~cpu_mrq_n & ~cpu_rd_n);
        wrb_n   = ~(~cpu_mrq_n & cpu_rd_n);
        lcd_gnt = 1'b0;
        if (state_q == LACC) begin
            ma      = addr_q;
            roe_n   = 1'b0;
            wrb_n   = 1'b1;
            lcd_gnt = 1'b1;
        end
        wait_n = ~(((state_q == LACC) | (state_q == TURN)) & ~cpu_mrq_n);
        busy   = (state_q != IDLE);
    end

    assign lcd_ack  = ack_q;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter with ACC_CYC=2 and
// STARVE_LIMIT=4. Inputs change 1 time unit after each rising edge; outputs
// are compared 1 time unit later, well clear of the next edge.

module tb_mem_arbiter;

    logic        mck;
    logic        rin;
    logic [21:0] cpu_ma;
    logic        cpu_mrq_n;
    logic        cpu_rd_n;
    logic        lcd_en;
    logic        lcd_req;
    logic [21:0] lcd_addr;
    logic [7:0]  mem_di;
    logic [21:0] ma;
    logic        roe_n;
    logic        wrb_n;
    logic        wait_n;
    logic        lcd_gnt;
    logic        lcd_ack;
    logic [7:0]  lcd_data;
    logic        busy;

    int compareCount  = 0;
    int mismatchCount = 0;

    mem_arbiter #(
        .ACC_CYC      (2),
        .STARVE_LIMIT (4)
    ) dut (
        .mck       (mck),
        .rin       (rin),
        .cpu_ma    (cpu_ma),
        .cpu_mrq_n (cpu_mrq_n),
        .cpu_rd_n  (cpu_rd_n),
        .lcd_en    (lcd_en),
        .lcd_req   (lcd_req),
        .lcd_addr  (lcd_addr),
        .mem_di    (mem_di),
        .ma        (ma),
        .roe_n     (roe_n),
        .wrb_n     (wrb_n),
        .wait_n    (wait_n),
        .lcd_gnt   (lcd_gnt),
        .lcd_ack   (lcd_ack),
        .lcd_data  (lcd_data),
        .busy      (busy)
    );

    // 10-unit master clock.
    initial begin
        mck = 1'b0;
        forever #5 mck = ~mck;
    end

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to the next cycle: 1 unit past the rising edge.
    task automatic nextCycle();
        @(posedge mck);
        #1;
    endtask

    // Drive all functional inputs in one go, then let combinational
    // outputs settle before any comparison.
    task automatic applyStimulus(input logic mrqN, input logic rdN,
                                 input logic [21:0] cpuAddr,
                                 input logic en, input logic req,
                                 input logic [21:0] lAddr,
                                 input logic [7:0] di);
        cpu_mrq_n = mrqN;
        cpu_rd_n  = rdN;
        cpu_ma    = cpuAddr;
        lcd_en    = en;
        lcd_req   = req;
        lcd_addr  = lAddr;
        mem_di    = di;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [14:0] ackMask;
        logic [14:0] gntMask;

        rin = 1'b1;
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b0, 1'b0, 22'h000000, 8'h00);
        nextCycle();
        nextCycle();

        // Reset state: CPU owns an idle bus.
        $display("[TB] reset values");
        checkOutput("rst_busy",  busy,     1'b0);
        checkOutput("rst_gnt",   lcd_gnt,  1'b0);
        checkOutput("rst_ack",   lcd_ack,  1'b0);
        checkOutput("rst_data",  lcd_data, 8'h00);
        checkOutput("rst_wait",  wait_n,   1'b1);
        checkOutput("rst_roe",   roe_n,    1'b1);
        checkOutput("rst_wrb",   wrb_n,    1'b1);
        rin = 1'b0;
        nextCycle();

        // Scenario 1: idle grant.
        $display("[TB] idle grant");
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b1, 22'h080123, 8'hA5);
        checkOutput("s1_c0_busy", busy, 1'b0);
        nextCycle();
        checkOutput("s1_c1_gnt", lcd_gnt, 1'b1);
        checkOutput("s1_c1_ma",  ma,      22'h080123);
        checkOutput("s1_c1_roe", roe_n,   1'b0);
        checkOutput("s1_c1_wrb", wrb_n,   1'b1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b0, 22'h000000, 8'hA5);
        checkOutput("s1_c2_gnt", lcd_gnt, 1'b1);
        checkOutput("s1_c2_ma",  ma,      22'h080123);
        checkOutput("s1_c2_roe", roe_n,   1'b0);
        nextCycle();
        checkOutput("s1_c3_ack",  lcd_ack,  1'b1);
        checkOutput("s1_c3_data", lcd_data, 8'hA5);
        checkOutput("s1_c3_gnt",  lcd_gnt,  1'b0);
        checkOutput("s1_c3_busy", busy,     1'b1);
        nextCycle();
        checkOutput("s1_c4_busy", busy,     1'b0);
        checkOutput("s1_c4_ack",  lcd_ack,  1'b0);
        checkOutput("s1_c4_data", lcd_data, 8'hA5);

        // Scenario 2: CPU read starts during the LCD access.
        $display("[TB] collision");
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b1, 22'h012345, 8'h3C);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 22'h200010, 1'b1, 1'b0, 22'h000000, 8'h3C);
        checkOutput("s2_c1_wait", wait_n, 1'b0);
        checkOutput("s2_c1_ma",   ma,     22'h012345);
        nextCycle();
        checkOutput("s2_c2_wait", wait_n, 1'b0);
        nextCycle();
        checkOutput("s2_c3_wait", wait_n,   1'b0);
        checkOutput("s2_c3_ma",   ma,       22'h200010);
        checkOutput("s2_c3_roe",  roe_n,    1'b0);
        checkOutput("s2_c3_data", lcd_data, 8'h3C);
        nextCycle();
        checkOutput("s2_c4_wait", wait_n, 1'b1);
        checkOutput("s2_c4_roe",  roe_n,  1'b0);
        checkOutput("s2_c4_ma",   ma,     22'h200010);
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b0, 22'h000000, 8'h00);
        nextCycle();

        // Scenario 3: a starved request steals a held CPU read.
        $display("[TB] starvation steal");
        applyStimulus(1'b0, 1'b0, 22'h200020, 1'b1, 1'b1, 22'h0ABCDE, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("s3_idle%0d_gnt", i), lcd_gnt, 1'b0);
            checkOutput($sformatf("s3_idle%0d_wait", i), wait_n, 1'b1);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 22'h200020, 1'b1, 1'b0, 22'h000000, 8'h5A);
        checkOutput("s3_lacc_gnt",  lcd_gnt, 1'b1);
        checkOutput("s3_lacc_wait", wait_n,  1'b0);
        checkOutput("s3_lacc_ma",   ma,      22'h0ABCDE);
        nextCycle();
        checkOutput("s3_lacc2_wait", wait_n, 1'b0);
        nextCycle();
        checkOutput("s3_turn_ack",  lcd_ack,  1'b1);
        checkOutput("s3_turn_data", lcd_data, 8'h5A);
        checkOutput("s3_turn_wait", wait_n,   1'b0);
        nextCycle();
        checkOutput("s3_done_wait", wait_n, 1'b1);
        checkOutput("s3_done_roe",  roe_n,  1'b0);
        checkOutput("s3_done_ma",   ma,     22'h200020);
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b0, 22'h000000, 8'h00);
        nextCycle();

        // Scenario 4: a CPU write is never stolen, even when starved.
        $display("[TB] write protection");
        applyStimulus(1'b0, 1'b1, 22'h200030, 1'b1, 1'b1, 22'h033333, 8'h96);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("s4_w%0d_gnt", i), lcd_gnt, 1'b0);
            checkOutput($sformatf("s4_w%0d_wrb", i), wrb_n,   1'b0);
            nextCycle();
        end
        checkOutput("s4_starve", 32'(dut.starve_q), 32'd4);
        applyStimulus(1'b1, 1'b1, 22'h200030, 1'b1, 1'b1, 22'h033333, 8'h96);
        checkOutput("s4_rel_wrb",  wrb_n,   1'b1);
        checkOutput("s4_rel_gnt",  lcd_gnt, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b0, 22'h000000, 8'h96);
        checkOutput("s4_grant_gnt", lcd_gnt, 1'b1);
        checkOutput("s4_grant_ma",  ma,      22'h033333);
        nextCycle();
        nextCycle();
        checkOutput("s4_ack",  lcd_ack,  1'b1);
        checkOutput("s4_data", lcd_data, 8'h96);
        nextCycle();

        // Scenario 5: reset during an access aborts it with no ack.
        $display("[TB] reset mid-access");
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b1, 22'h0F0F0F, 8'h77);
        nextCycle();
        checkOutput("s5_lacc_gnt", lcd_gnt, 1'b1);
        rin = 1'b1;
        applyStimulus(1'b0, 1'b0, 22'h200040, 1'b1, 1'b0, 22'h000000, 8'h77);
        nextCycle();
        rin = 1'b0;
        #1;
        checkOutput("s5_gnt",  lcd_gnt,  1'b0);
        checkOutput("s5_busy", busy,     1'b0);
        checkOutput("s5_ack",  lcd_ack,  1'b0);
        checkOutput("s5_data", lcd_data, 8'h00);
        checkOutput("s5_wait", wait_n,   1'b1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("s5_post%0d_ack", i), lcd_ack, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b0, 22'h000000, 8'h00);
        nextCycle();

        // Scenario 6: held request gives an ack every 4 cycles; dropping
        // lcd_en in cycle 9 (LACC) lets that fetch finish, then stops.
        $display("[TB] held request and lcd_en");
        ackMask = 15'h0888;
        gntMask = 15'h0666;
        applyStimulus(1'b1, 1'b1, 22'h000000, 1'b1, 1'b1, 22'h111111, 8'hC3);
        for (int i = 0; i < 15; i++) begin
            if (i == 9) begin
                applyStimulus(1'b1, 1'b1, 22'h000000, 1'b0, 1'b1, 22'h111111, 8'hC3);
            end
            checkOutput($sformatf("s6_c%0d_ack", i), lcd_ack, ackMask[i]);
            checkOutput($sformatf("s6_c%0d_gnt", i), lcd_gnt, gntMask[i]);
            nextCycle();
        end
        checkOutput("s6_data", lcd_data, 8'hC3);
        checkOutput("s6_busy", busy,     1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the 22-bit physical memory bus (ma, roe_n, wrb_n) between the Z80 and the LCD fetch engine.
- Sits between the blink address/strobe decode and the memory slots.
- CPU has priority. The LCD is granted idle bus slots, or steals a CPU read cycle via wait_n once starved.
- Writes are never interrupted.

Parameters:
ACC_CYC, 2, mck cycles roe_n is held low per LCD read (1..15)
STARVE_LIMIT, 24, cycles a pending LCD request waits before forcing a steal (1..255)

Ports:
mck  in  1  master clock
rin  in  1  synchronous active-high reset
cpu_ma  in  22  physical address from segment decode
cpu_mrq_n  in  1  Z80 MREQ
cpu_rd_n  in  1  Z80 RD
lcd_en  in  1  LCD fetch enable (from com register)
lcd_req  in  1  LCD fetch request, level
lcd_addr  in  22  LCD fetch address, sampled at grant
mem_di  in  8  memory read data
ma  out  22  physical address to slots
roe_n  out  1  memory output enable
wrb_n  out  1  memory write enable
wait_n  out  1  Z80 WAIT
lcd_gnt  out  1  high while LCD owns bus
lcd_ack  out  1  one-cycle pulse, lcd_data valid
lcd_data  out  8  fetched byte, registered
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock mck. rin is synchronous and active-high. All state updates on posedge mck.
- Reset values:
  - state=IDLE, starve_cnt=0, acc_cnt=0, addr_q=0.
  - lcd_data=8'h00, lcd_ack=0, lcd_gnt=0, busy=0, wait_n=1.
  - ma/roe_n/wrb_n follow the CPU.
- Reset mid-access aborts immediately. The aborted fetch produces no ack.
- FSM states: IDLE, LACC, TURN.
- IDLE:
  - Grants when lcd_en & lcd_req & (cpu_mrq_n | (starve_cnt==STARVE_LIMIT & !cpu_rd_n)).
  - On grant: addr_q<=lcd_addr, acc_cnt<=ACC_CYC-1, starve_cnt<=0, go LACC.
  - A CPU write (mrq low, rd high) is never stolen, even when starved. The steal waits for MREQ to rise.
- LACC:
  - LCD owns the bus for exactly ACC_CYC cycles. lcd_gnt=1.
  - acc_cnt decrements each cycle. When acc_cnt==0: lcd_data<=mem_di, lcd_ack<=1, go TURN.
- TURN:
  - 1-cycle bus turnaround. lcd_ack=1 for this cycle only; the CPU owns the bus.
  - Always returns to IDLE.
  - A still-high lcd_req is a new request. Back-to-back fetches are therefore spaced ACC_CYC+2 cycles apart.
- Output mux, combinational on registered state:
  - LACC: ma=addr_q, roe_n=0, wrb_n=1.
  - Otherwise: ma=cpu_ma, roe_n=!(!cpu_mrq_n & !cpu_rd_n), wrb_n=!(!cpu_mrq_n & cpu_rd_n).
- wait_n = !((state==LACC | state==TURN) & !cpu_mrq_n).
  - A CPU cycle that starts or is stolen during an LCD access is held until the bus returns.
- starve_cnt:
  - Cleared when lcd_req=0, lcd_en=0, or on grant.
  - Increments each IDLE cycle with lcd_req pending and no grant. Saturates at STARVE_LIMIT (no wrap).
  - 8 bits wide.
- lcd_en falling during LACC/TURN: the access completes and acks normally. No new grant follows.
- lcd_data holds its value until the next completed access.

Test Plan:
1. Idle grant (ACC_CYC=2):
   - Stimulus: cpu_mrq_n=1; lcd_req rises at cycle 0 with lcd_addr=22'h080123, mem_di=8'hA5.
   - Required: cycles 1-2 lcd_gnt=1, ma=22'h080123, roe_n=0, wrb_n=1; cycle 3 lcd_ack=1, lcd_data=8'hA5; cycle 4 busy=0.
2. Collision:
   - Stimulus: cpu_mrq_n falls during LACC cycle 1 (CPU read, cpu_ma=22'h200010).
   - Required: wait_n=0 through TURN; ma=22'h200010, roe_n=0 from TURN onwards; wait_n=1 in the cycle the FSM returns to IDLE.
3. Starvation steal (STARVE_LIMIT=4):
   - Stimulus: CPU read with cpu_mrq_n held low; lcd_req held.
   - Required: grant on the 5th IDLE cycle (starve_cnt==4); wait_n=0 during LACC/TURN; CPU read completes after.
4. Write protection:
   - Stimulus: same as scenario 3, but the CPU is in a write (cpu_rd_n=1) for 10 cycles.
   - Required: no grant; starve_cnt stays 4; wrb_n=0 throughout; grant in the first cycle cpu_mrq_n=1.
5. Reset mid-access:
   - Stimulus: assert rin during LACC.
   - Required: next cycle state=IDLE, lcd_gnt=0, lcd_ack never pulses, lcd_data=8'h00, wait_n=1.
6. Held request and lcd_en:
   - Stimulus: lcd_req held high continuously.
   - Required: acks every ACC_CYC+2 cycles; lcd_en=0 mid-LACC completes that ack, then no further grants.
